// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register directly upstream of the ALU. It captures
//            the decoded operands and resolves register forwarding from EX/MEM
//            and MEM/WB when an instruction is accepted. It also selects the
//            immediate. inA/inB/ALU_control go to the ALU through a
//            valid/ready handshake. A 2-entry skid buffer (output register
//            plus skid register) lets in_ready come straight from a flop.
//            flush empties the stage for branch redirects.
// Ports    : clk, rst_n (async, active low), flush
//            in_*        : ID-side instruction plus in_valid/in_ready handshake
//            ex_fwd_*    : EX/MEM forwarding source (higher priority)
//            wb_fwd_*    : MEM/WB forwarding source
//            out_valid/out_ready, inA, inB, ALU_control, out_rd_addr,
//            out_reg_write : ALU-side handshake and payload
//            stall_cnt   : count of backpressured cycles
//                          (present only with ID_EX_STALL_COUNT_EN)
// Options  : `define ID_EX_STALL_COUNT_EN adds the saturating stall_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int RAW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [RAW-1:0]    in_rs1_addr,
    input  logic [RAW-1:0]    in_rs2_addr,
    input  logic [RAW-1:0]    in_rd_addr,
    input  logic              in_reg_write,
    input  logic [CTRL_W-1:0] in_ALU_control,
    input  logic              ex_fwd_valid,
    input  logic [RAW-1:0]    ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [RAW-1:0]    wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   inA,
    output logic [XLEN-1:0]   inB,
    output logic [CTRL_W-1:0] ALU_control,
    output logic [RAW-1:0]    out_rd_addr,
    output logic              out_reg_write
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Payload layout (LSB first): inA | inB | ALU_control | rd | reg_write
    localparam int PW = 2*XLEN + CTRL_W + RAW + 1;
    localparam logic [RAW-1:0] c_X0 = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [PW-1:0]   out_q, out_d;
    logic [PW-1:0]   skid_q, skid_d;

    logic            w_accept;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_b;
    logic [PW-1:0]   w_capture;

    // EX/MEM wins over MEM/WB; x0 is hard-wired zero and is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RAW-1:0]  addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_v,
        input logic [RAW-1:0]  ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_v,
        input logic [RAW-1:0]  wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (ex_v && (ex_rd == addr) && (addr != c_X0)) begin
            return ex_data;
        end else if (wb_v && (wb_rd == addr) && (addr != c_X0)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    assign w_accept  = in_valid && in_ready_q;
    assign w_fwd_rs1 = fwd_sel(in_rs1_addr, in_rs1_data, ex_fwd_valid, ex_fwd_rd,
                               ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign w_fwd_rs2 = fwd_sel(in_rs2_addr, in_rs2_data, ex_fwd_valid, ex_fwd_rd,
                               ex_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
    assign w_op_b    = in_use_imm ? in_imm : w_fwd_rs2;
    assign w_capture = {in_reg_write, in_rd_addr, in_ALU_control, w_op_b, w_fwd_rs1};

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        out_d      = out_q;
        skid_d     = skid_q;

        if (flush) begin
            // Payload is left alone; an EMPTY state masks it via out_valid.
            state_d    = ST_EMPTY;
            in_ready_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        out_d   = w_capture;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept && out_ready) begin
                        out_d = w_capture;
                    end else if (w_accept) begin
                        // Downstream stalled while ID already pushed: park it.
                        skid_d     = w_capture;
                        in_ready_d = 1'b0;
                        state_d    = ST_SKID;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        out_d      = skid_q;
                        in_ready_d = 1'b1;
                        state_d    = ST_FULL;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != ST_EMPTY);
    assign inA           = out_q[XLEN-1:0];
    assign inB           = out_q[XLEN +: XLEN];
    assign ALU_control   = out_q[2*XLEN +: CTRL_W];
    assign out_rd_addr   = out_q[2*XLEN+CTRL_W +: RAW];
    assign out_reg_write = out_q[PW-1];

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating; deliberately untouched by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed, self-checking bench for id_ex_stage. It covers reset,
//            forwarding priority, x0, immediate select, skid backpressure,
//            flush, a streaming run, asynchronous reset mid-transfer and,
//            when ID_EX_STALL_COUNT_EN is defined, the stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_reg_write;
    logic [3:0]  in_ALU_control;
    logic        ex_fwd_valid, wb_fwd_valid;
    logic [4:0]  ex_fwd_rd, wb_fwd_rd;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] inA, inB;
    logic [3:0]  ALU_control;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;
`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage #(.XLEN(32), .CTRL_W(4), .RAW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_use_imm     (in_use_imm),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rd_addr     (in_rd_addr),
        .in_reg_write   (in_reg_write),
        .in_ALU_control (in_ALU_control),
        .ex_fwd_valid   (ex_fwd_valid),
        .ex_fwd_rd      (ex_fwd_rd),
        .ex_fwd_data    (ex_fwd_data),
        .wb_fwd_valid   (wb_fwd_valid),
        .wb_fwd_rd      (wb_fwd_rd),
        .wb_fwd_data    (wb_fwd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .inA            (inA),
        .inB            (inB),
        .ALU_control    (ALU_control),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write)
`ifdef ID_EX_STALL_COUNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v,
                         input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d,
                         input logic [31:0] imm, input logic ui,
                         input logic [4:0] rd, input logic rw, input logic [3:0] ctl);
        in_valid       = v;
        in_rs1_addr    = r1a;
        in_rs1_data    = r1d;
        in_rs2_addr    = r2a;
        in_rs2_data    = r2d;
        in_imm         = imm;
        in_use_imm     = ui;
        in_rd_addr     = rd;
        in_reg_write   = rw;
        in_ALU_control = ctl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_inA", 64'(inA), 64'd0);
        chk("rst_inB", 64'(inB), 64'd0);
        chk("rst_ctrl", 64'(ALU_control), 64'd0);
        chk("rst_rd", 64'(out_rd_addr), 64'd0);
        chk("rst_rw", 64'(out_reg_write), 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
        chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        // ---------------- basic capture with immediate ----------------
        drive(1, 5'd3, 32'h10, 5'd0, 32'h0, 32'h5, 1, 5'd1, 1, 4'b0000);
        tick();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_inA", 64'(inA), 64'h10);
        chk("t1_inB", 64'(inB), 64'h5);
        chk("t1_ctrl", 64'(ALU_control), 64'd0);
        chk("t1_rd", 64'(out_rd_addr), 64'd1);
        chk("t1_rw", 64'(out_reg_write), 64'd1);
        tick();
        chk("t1_drain", 64'(out_valid), 64'd0);

        // ---------------- forwarding ----------------
        // EX and WB both match rs1=7: EX wins. rs2=9 matches nobody: RF data.
        ex_fwd_valid = 1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hAAAA;
        wb_fwd_valid = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hBBBB;
        drive(1, 5'd7, 32'h1234, 5'd9, 32'h99, 32'hFFFF, 0, 5'd2, 1, 4'b0011);
        tick();
        chk("fwd_ex_prio_inA", 64'(inA), 64'hAAAA);
        chk("fwd_none_inB", 64'(inB), 64'h99);
        chk("fwd_ctrl", 64'(ALU_control), 64'h3);
        // x0 never forwarded on rs1; rs2=5 picked up from WB.
        ex_fwd_rd = 5'd0; ex_fwd_data = 32'hDEAD;
        wb_fwd_rd = 5'd5; wb_fwd_data = 32'hBBBB;
        drive(1, 5'd0, 32'h55, 5'd5, 32'h66, 32'h0, 0, 5'd3, 0, 4'b0101);
        tick();
        chk("fwd_x0_inA", 64'(inA), 64'h55);
        chk("fwd_wb_inB", 64'(inB), 64'hBBBB);
        chk("fwd_rw0", 64'(out_reg_write), 64'd0);
        // EX match but not valid -> WB; immediate overrides a forwarded rs2.
        ex_fwd_valid = 0; ex_fwd_rd = 5'd4; ex_fwd_data = 32'hEEEE;
        wb_fwd_rd = 5'd4; wb_fwd_data = 32'hCC;
        drive(1, 5'd4, 32'h44, 5'd4, 32'h45, 32'h77, 1, 5'd4, 1, 4'b0110);
        tick();
        chk("fwd_exinv_inA", 64'(inA), 64'hCC);
        chk("fwd_imm_inB", 64'(inB), 64'h77);
        ex_fwd_valid = 0; wb_fwd_valid = 0;
        in_valid = 0;
        tick();
        chk("fwd_drain", 64'(out_valid), 64'd0);

        // ---------------- skid backpressure ----------------
        out_ready = 0;
        drive(1, 5'd1, 32'hA0, 5'd0, 32'h0, 32'h0, 0, 5'd10, 1, 4'h1);
        tick();
        chk("bp0_valid", 64'(out_valid), 64'd1);
        chk("bp0_inA", 64'(inA), 64'hA0);
        chk("bp0_ready", 64'(in_ready), 64'd1);
        drive(1, 5'd1, 32'hB0, 5'd0, 32'h0, 32'h0, 0, 5'd11, 1, 4'h2);
        tick();
        chk("bp1_ready", 64'(in_ready), 64'd0);
        chk("bp1_inA_held", 64'(inA), 64'hA0);
        drive(1, 5'd1, 32'hC0, 5'd0, 32'h0, 32'h0, 0, 5'd12, 1, 4'h3);
        tick();
        chk("bp2_ready", 64'(in_ready), 64'd0);
        chk("bp2_valid", 64'(out_valid), 64'd1);
        chk("bp2_inA_held", 64'(inA), 64'hA0);
        chk("bp2_ctrl_held", 64'(ALU_control), 64'h1);
        in_valid = 0; out_ready = 1;
        tick();
        chk("bp3_valid", 64'(out_valid), 64'd1);
        chk("bp3_inA_second", 64'(inA), 64'hB0);
        chk("bp3_rd_second", 64'(out_rd_addr), 64'd11);
        chk("bp3_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp4_empty", 64'(out_valid), 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
        chk("bp_stall", 64'(stall_cnt), 64'd2);
`endif

        // ---------------- flush in SKID ----------------
        out_ready = 0;
        drive(1, 5'd1, 32'hD0, 5'd0, 32'h0, 32'h0, 0, 5'd13, 1, 4'h4);
        tick();
        drive(1, 5'd1, 32'hE0, 5'd0, 32'h0, 32'h0, 0, 5'd14, 1, 4'h5);
        tick();
        chk("fl_skid_ready", 64'(in_ready), 64'd0);
        flush = 1;
        drive(1, 5'd1, 32'hF0, 5'd0, 32'h0, 32'h0, 0, 5'd15, 1, 4'h6);
        tick();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("fl_nothing1", 64'(out_valid), 64'd0);
        tick();
        chk("fl_nothing2", 64'(out_valid), 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
        chk("fl_stall", 64'(stall_cnt), 64'd4);
`endif

        // ---------------- back-to-back stream ----------------
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'd2, 32'h100 + 32'(i), 5'd0, 32'h0, 32'h0, 0, 5'(i), 1, 4'(i));
            tick();
            chk("st_valid", 64'(out_valid), 64'd1);
            chk("st_inA", 64'(inA), 64'h100 + 64'(i));
            chk("st_ctrl", 64'(ALU_control), 64'(i));
            chk("st_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 0;
        tick();
        chk("st_drain", 64'(out_valid), 64'd0);

        // ---------------- async reset mid-transfer ----------------
        out_ready = 0;
        drive(1, 5'd6, 32'h77, 5'd0, 32'h0, 32'h0, 0, 5'd6, 1, 4'h7);
        tick();
        in_valid = 0;
        chk("mr_loaded", 64'(out_valid), 64'd1);
        rst_n = 0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_inA", 64'(inA), 64'd0);
        chk("mr_ctrl", 64'(ALU_control), 64'd0);
        chk("mr_rd", 64'(out_rd_addr), 64'd0);
        chk("mr_rw", 64'(out_reg_write), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
`ifdef ID_EX_STALL_COUNT_EN
        chk("mr_stall", 64'(stall_cnt), 64'd0);
`endif
        tick();
        rst_n = 1; out_ready = 1;
        tick();
        chk("mr_post_empty", 64'(out_valid), 64'd0);

        // ---------------- stall counter: 5 stalls, flush, reset ----------------
        out_ready = 0;
        drive(1, 5'd8, 32'h88, 5'd0, 32'h0, 32'h0, 0, 5'd8, 1, 4'h8);
        tick();
        in_valid = 0;
        repeat (5) tick();
        chk("sc_held", 64'(out_valid), 64'd1);
        chk("sc_inA", 64'(inA), 64'h88);
`ifdef ID_EX_STALL_COUNT_EN
        chk("sc_five", 64'(stall_cnt), 64'd5);
`endif
        flush = 1; out_ready = 1;
        tick();
        flush = 0;
        chk("sc_flush_valid", 64'(out_valid), 64'd0);
        tick();
        chk("sc_flush_stays_empty", 64'(out_valid), 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
        chk("sc_after_flush", 64'(stall_cnt), 64'd5);
        rst_n = 0;
        #1;
        chk("sc_reset", 64'(stall_cnt), 64'd0);
        tick();
        rst_n = 1;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
